// File: rtl/gate_deadtime_gen_pkg.sv
// Shared definitions for the inverter gate-drive and timer-based filter blocks.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package gate_deadtime_gen_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DT_HI = 3'd1,
        ST_HI_ON = 3'd2,
        ST_DT_LO = 3'd3,
        ST_LO_ON = 3'd4
    } gate_state_t;

    // One increment of the shared free-running timer.
    localparam int unsigned TICK_PERIOD_NS = 600;

    // Defaults shared with the input signal filters, in timer ticks.
    localparam logic [7:0] DEAD_TIME_DEF = 8'd4;
    localparam logic [7:0] MIN_ON_DEF    = 8'd10;

    function automatic logic is_dt(input gate_state_t s);
        return (s == ST_DT_HI) || (s == ST_DT_LO);
    endfunction

    function automatic logic is_on(input gate_state_t s);
        return (s == ST_HI_ON) || (s == ST_LO_ON);
    endfunction

endpackage

// File: rtl/gate_deadtime_gen_tick_deadline.sv
// Deadline compare-match against the shared tick timer: cc = timer + n + 1 on load.
// Latency: cc updates 1 clk after load; match is combinational on timer/cc.
// Backpressure: none; a stalled timer simply delays the match.
// Ports: clk, rst (async, active-low), load, n[7:0], timer[7:0] in; match out.
module tick_deadline (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] n,
    input  logic [7:0] timer,
    output logic       match
);

    logic [7:0] cc;

    // The +1 makes the interval at least n whole ticks even when loaded late
    // in a tick. Mod-256 wrap is intended: equality still finds the deadline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc <= 8'd0;
        end else if (load) begin
            cc <= timer + n + 8'd1;
        end
    end

    assign match = (timer == cc);

endmodule

// File: rtl/gate_deadtime_gen.sv
// Complementary half-bridge gate driver with dead time and minimum on-time.
// Latency: pwm_in edge -> active gate falls 3 clk later (2 sync + 1), subject to MIN_ON.
// Backpressure: none; command changes during MIN_ON are held off until mature.
// Ports: clk, rst (async, active-low), timer[7:0], en, pwm_in (async), fault in;
//        gate_hs, gate_ls, dt_active, fault_lat out (all registered).
module gate_deadtime_gen
    import gate_deadtime_gen_pkg::*;
#(
    parameter logic [7:0] DEAD_TIME = DEAD_TIME_DEF,
    parameter logic [7:0] MIN_ON    = MIN_ON_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] timer,
    input  logic       en,
    input  logic       pwm_in,
    input  logic       fault,
    output logic       gate_hs,
    output logic       gate_ls,
    output logic       dt_active,
    output logic       fault_lat
);

    gate_state_t st;
    gate_state_t ns;
    logic        pwm_meta;
    logic        pwm_s;
    logic        mature_q;
    logic        mature_now;
    logic        match;
    logic        load;
    logic [7:0]  n;

    // Two-flop synchroniser; nothing downstream looks at pwm_in directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_meta <= 1'b0;
            pwm_s    <= 1'b0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_s    <= pwm_meta;
        end
    end

    tick_deadline u_deadline (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .n     (n),
        .timer (timer),
        .match (match)
    );

    // The match only lasts while timer == cc; the sticky bit remembers that
    // MIN_ON has expired so a held-off command still takes effect later.
    assign mature_now = mature_q | match;

    always_comb begin
        ns   = st;
        load = 1'b0;
        n    = DEAD_TIME;

        unique case (st)
            ST_OFF: begin
                if (en && !fault_lat) begin
                    ns = pwm_s ? ST_DT_HI : ST_DT_LO;
                end
            end
            ST_DT_HI: begin
                if (!pwm_s)     ns = ST_DT_LO;
                else if (match) ns = ST_HI_ON;
            end
            ST_HI_ON: begin
                if (mature_now && !pwm_s) ns = ST_DT_LO;
            end
            ST_DT_LO: begin
                if (pwm_s)      ns = ST_DT_HI;
                else if (match) ns = ST_LO_ON;
            end
            ST_LO_ON: begin
                if (mature_now && pwm_s) ns = ST_DT_HI;
            end
            default: ns = ST_OFF;
        endcase

        // Shutdown overrides everything, including an in-progress MIN_ON.
        if (fault || !en) begin
            ns = ST_OFF;
        end

        // Retargeting between dead-time states keeps cc: both gates have
        // already been off since the first dead-time entry.
        load = (ns != st) && (ns != ST_OFF) && !(is_dt(st) && is_dt(ns));
        n    = is_on(ns) ? MIN_ON : DEAD_TIME;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= ST_OFF;
            mature_q  <= 1'b0;
            fault_lat <= 1'b0;
            gate_hs   <= 1'b0;
            gate_ls   <= 1'b0;
            dt_active <= 1'b0;
        end else begin
            st <= ns;

            if (load) begin
                mature_q <= 1'b0;
            end else if (is_on(st) && match) begin
                mature_q <= 1'b1;
            end

            if (fault) begin
                fault_lat <= 1'b1;
            end else if (!en) begin
                fault_lat <= 1'b0;
            end

            // Decoding from ns keeps the two gate flops mutually exclusive.
            gate_hs   <= (ns == ST_HI_ON);
            gate_ls   <= (ns == ST_LO_ON);
            dt_active <= is_dt(ns);
        end
    end

endmodule
